// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU for the MIPS datapath, with an iterative
// multiply/divide unit and the architectural HI/LO registers.
//
// The single-cycle operations are purely combinational on out/zero.
// MULT/DIV run WIDTH one-bit iterations plus one sign-fix cycle. busy is
// high for that whole time, and the control unit stalls the PC while it
// is set. MTHI/MTLO write HI/LO directly on an accepted start.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous, active-low reset
//   in1      in   operand A / shift amount / MTHI-MTLO source
//   in2      in   operand B
//   ALUCtrl  in   operation select (5 bits)
//   Sign     in   1 = signed/arithmetic, 0 = unsigned/logical
//   start    in   launch MULT/DIV/MTHI/MTLO
//   out      out  combinational result
//   zero     out  out == 0
//   busy     out  multiply/divide in progress
//   done     out  one-cycle pulse after HI/LO take a new result
//   hi, lo   out  HI/LO registers
module alu_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [4:0]         ALUCtrl,
  input  logic               Sign,
  input  logic               start,
  output logic [WIDTH-1:0]   out,
  output logic               zero,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_OR   = 5'h04;
  localparam logic [4:0] OP_XOR  = 5'h05;
  localparam logic [4:0] OP_NOR  = 5'h06;
  localparam logic [4:0] OP_SL   = 5'h07;
  localparam logic [4:0] OP_SR   = 5'h08;
  localparam logic [4:0] OP_SLT  = 5'h09;
  localparam logic [4:0] OP_MULT = 5'h0A;
  localparam logic [4:0] OP_DIV  = 5'h0B;
  localparam logic [4:0] OP_MFHI = 5'h0C;
  localparam logic [4:0] OP_MFLO = 5'h0D;
  localparam logic [4:0] OP_MTHI = 5'h0E;
  localparam logic [4:0] OP_MTLO = 5'h0F;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [SHAMT_W-1:0] cnt;

  // Iteration registers. For multiply, {acc, mq} is the running product,
  // with the multiplier shifting out of mq. For divide, acc is the partial
  // remainder and mq takes the dividend in and the quotient out. opm is the
  // multiplicand or the divisor.
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   opm;
  logic [WIDTH-1:0]   dvd;
  logic               op_div;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                input logic             neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                   input logic               neg);
    return neg ? -x : x;
  endfunction

  // ---------------------------------------------------------------------
  // Combinational ALU
  // ---------------------------------------------------------------------
  logic [SHAMT_W-1:0]      shamt;
  logic signed [WIDTH-1:0] sra_res;
  logic                    slt_s;
  logic                    slt_u;

  assign shamt   = in1[SHAMT_W-1:0];
  assign sra_res = $signed(in2) >>> shamt;
  assign slt_s   = $signed(in1) < $signed(in2);
  assign slt_u   = in1 < in2;

  always_comb begin
    out = '0;
    case (ALUCtrl)
      OP_NOP:  out = in2;
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_AND:  out = in1 & in2;
      OP_OR:   out = in1 | in2;
      OP_XOR:  out = in1 ^ in2;
      OP_NOR:  out = ~(in1 | in2);
      OP_SL:   out = in2 << shamt;
      OP_SR:   out = Sign ? sra_res : (in2 >> shamt);
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, (Sign ? slt_s : slt_u)};
      OP_MFHI: out = hi;
      OP_MFLO: out = lo;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

  // ---------------------------------------------------------------------
  // Multiply/divide launch and single-step datapath
  // ---------------------------------------------------------------------
  logic             idle_like;
  logic             go_mul;
  logic             go_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shl;
  logic [WIDTH:0]   div_diff;

  // DONE accepts a new start just like IDLE, so back-to-back ops lose no cycle.
  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign go_mul    = start && idle_like && (ALUCtrl == OP_MULT);
  assign go_div    = start && idle_like && (ALUCtrl == OP_DIV);

  assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opm} : {(WIDTH+1){1'b0}});
  assign div_shl  = {acc, mq[WIDTH-1]};
  // The MSB of the difference is set exactly when the shifted remainder is
  // below the divisor, because the remainder is always below the divisor.
  assign div_diff = div_shl - {1'b0, opm};

  always_ff @(posedge clk) begin
    if (go_mul || go_div) begin
      acc      <= '0;
      mq       <= go_div ? magnitude(in1, Sign) : magnitude(in2, Sign);
      opm      <= go_div ? magnitude(in2, Sign) : magnitude(in1, Sign);
      dvd      <= in1;
      op_div   <= go_div;
      neg_q    <= Sign & (in1[WIDTH-1] ^ in2[WIDTH-1]);
      neg_r    <= Sign & in1[WIDTH-1];
      div_zero <= (in2 == '0);
    end else if (state == S_MUL) begin
      acc <= mul_sum[WIDTH:1];
      mq  <= {mul_sum[0], mq[WIDTH-1:1]};
    end else if (state == S_DIV) begin
      if (!div_diff[WIDTH]) begin
        acc <= div_diff[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], 1'b1};
      end else begin
        acc <= div_shl[WIDTH-1:0];
        mq  <= {mq[WIDTH-2:0], 1'b0};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sign correction
  // ---------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // The -2^(W-1) / -1 overflow needs no special case. The magnitudes give
  // a quotient of 2^(W-1), the result sign is positive, and the truncated
  // value reads back as 0x80..0.
  always_comb begin
    prod_fix = cond_neg2({acc, mq}, neg_q);
    fix_hi   = '0;
    fix_lo   = '0;
    if (!op_div) begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end else if (div_zero) begin
      fix_hi = dvd;
      fix_lo = '1;
    end else begin
      fix_hi = cond_neg(acc, neg_r);
      fix_lo = cond_neg(mq, neg_q);
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM, HI/LO and status outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (start) begin
            case (ALUCtrl)
              OP_MULT: begin
                state <= S_MUL;
                busy  <= 1'b1;
                cnt   <= SHAMT_W'(WIDTH-1);
              end
              OP_DIV: begin
                state <= S_DIV;
                busy  <= 1'b1;
                cnt   <= SHAMT_W'(WIDTH-1);
              end
              OP_MTHI: hi <= in1;
              OP_MTLO: lo <= in1;
              default: ;
            endcase
          end
        end
        S_MUL, S_DIV: begin
          if (cnt == '0) begin
            state <= S_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_FIX: begin
          hi    <= fix_hi;
          lo    <= fix_lo;
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation ALU for the MIPS datapath.
- Keeps the existing single-cycle combinational operations and adds an iterative multiply/divide unit with architectural HI/LO registers.
- Supports the MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO instructions.
- Sits in the EX stage; the control unit stalls the PC while busy=1.

Parameters:
- WIDTH, 32: operand, result and HI/LO width.
- SHAMT_W, 5: shift-amount bits taken from in1. Must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in1  input  WIDTH  operand A (shift amount for shifts; source for MTHI/MTLO).
- in2  input  WIDTH  operand B.
- ALUCtrl  input  5  operation select.
- Sign  input  1  1 = signed/arithmetic, 0 = unsigned/logical.
- start  input  1  launches a MULT/DIV/MTHI/MTLO when ALUCtrl selects one.
- out  output  WIDTH  combinational result.
- zero  output  1  out == 0.
- busy  output  1  multiply/divide in progress.
- done  output  1  one-cycle pulse; HI/LO now hold the new result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- ALUCtrl encoding:
  - 0x00 NOP (out=in2), 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR, 0x05 XOR, 0x06 NOR
  - 0x07 SL (in2 << in1[SHAMT_W-1:0])
  - 0x08 SR (arithmetic if Sign=1, else logical)
  - 0x09 SLT (true signed compare if Sign=1, unsigned if Sign=0; result 1 or 0, zero-extended)
  - 0x0A MULT, 0x0B DIV, 0x0C MFHI (out=hi), 0x0D MFLO (out=lo), 0x0E MTHI, 0x0F MTLO
  - all other codes: out=0
- out for 0x0A, 0x0B, 0x0E, 0x0F is 0.
- out is purely combinational, valid in the same cycle. ADD/SUB wrap modulo 2^WIDTH with no overflow flag.
- MTHI/MTLO: at a rising edge with start=1 and busy=0, hi<=in1 (MTHI) or lo<=in1 (MTLO). No busy, no done.
- FSM states: IDLE, MUL, DIV, FIX, DONE.
  - IDLE/DONE + start=1 + ALUCtrl=MULT -> MUL; with ALUCtrl=DIV -> DIV.
  - On entry: in1, in2 and Sign are latched, operands converted to magnitudes when Sign=1, result sign recorded, counter loaded with WIDTH-1. Later changes to inputs have no effect.
  - MUL: shift-add, one bit per cycle. DIV: restoring division, one quotient bit per cycle. Each runs exactly WIDTH cycles, counter reaching 0 -> FIX.
  - FIX: applies sign correction, writes hi/lo -> DONE.
  - DONE: done=1 for one cycle, busy=0. Next state IDLE, or MUL/DIV if a new start is accepted.
- busy=1 in MUL, DIV and FIX.
- Latency: start sampled at edge E. busy is high from E to E+WIDTH+1. hi/lo update at edge E+WIDTH+1. done is high in the cycle after that edge.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product.
- Divide result: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
- Divide by zero: lo = all ones, hi = dividend (in1). No trap.
- Signed overflow, -2^(WIDTH-1) / -1: lo = 0x80000000, hi = 0 (for WIDTH=32).
- start while busy=1: ignored, including MTHI/MTLO.
- start with any other ALUCtrl: no effect.
- MFHI/MFLO while busy return the old hi/lo; hi/lo change only at FIX.
- Reset (reset=0, asynchronous): FSM -> IDLE, hi=lo=0, busy=0, done=0, counter=0. A reset mid-operation aborts it, and no partial result reaches hi/lo.

Test Plan:
- WIDTH=32, MULT Sign=1, in1=0xFFFFFFFD (-3), in2=7, start at edge 0 -> busy high edges 0..33; done high after edge 33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT Sign=0, in1=in2=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV Sign=1, in1=0xFFFFFFF9 (-7), in2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV Sign=0, in1=7, in2=0 -> lo=0xFFFFFFFF, hi=7.
- Combinational checks:
  - SR Sign=1, in2=0x80000000, in1=4 -> out=0xF8000000.
  - SLT in1=1, in2=0xFFFFFFFF: Sign=0 -> out=1; Sign=1 -> out=0, zero=1.
- MTHI in1=0x12345678, then MFHI -> out=0x12345678.
  - Then start a MULT 5*5 and issue a second start at edge 3 -> second start ignored.
  - Assert reset=0 at edge 10 -> busy=0 immediately, hi=lo=0, no done pulse.
